high_score_tracker: RTL and testbench

//  Sits between ScoreModule and the four score_render digit instances.

---
 rtl/high_score_tracker_if.sv | 22 ++
 rtl/high_score_tracker.sv | 112 +++++++++++
 tb/tb_high_score_tracker.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/high_score_tracker_if.sv
// Signal bundle between the game logic, the high score tracker and the score digit renderers.
// The master side drives game events and the live score; the slave side returns what to display.
interface high_score_tracker_if;
    logic        i_game_tick;
    logic        i_game_start;
    logic        i_game_over;
    logic [15:0] i_score;
    logic [15:0] o_display_score;
    logic        o_display_blank;
    logic [15:0] o_high_score;
    logic        o_new_record;

    modport master (
        output i_game_tick, i_game_start, i_game_over, i_score,
        input  o_display_score, o_display_blank, o_high_score, o_new_record
    );

    modport slave (
        input  i_game_tick, i_game_start, i_game_over, i_score,
        output o_display_score, o_display_blank, o_high_score, o_new_record
    );
endinterface

// File: rtl/high_score_tracker.sv
// Session high score keeper and score display selector; blinks the high score
// for BLINK_TICKS game ticks after a game ends with a new record.
module high_score_tracker #(
    parameter int BLINK_TICKS = 40,
    parameter int BLINK_HALF  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    high_score_tracker_if.slave  bus
);

    localparam int TW = $clog2(BLINK_TICKS + 1);
    localparam int PW = $clog2(BLINK_HALF + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(BLINK_TICKS - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(BLINK_HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        PLAYING,
        CHECK,
        CELEB,
        HOLD
    } state_t;

    state_t        r_state;
    logic [15:0]   r_final_score;
    logic [15:0]   r_high_score;
    logic [15:0]   r_display_score;
    logic          r_display_blank;
    logic          r_new_record;
    logic [TW-1:0] r_tick_cnt;
    logic [PW-1:0] r_phase_cnt;

    // A game start overrides every other event, including a simultaneous game over or tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_final_score   <= '0;
            r_high_score    <= '0;
            r_display_score <= '0;
            r_display_blank <= 1'b0;
            r_new_record    <= 1'b0;
            r_tick_cnt      <= '0;
            r_phase_cnt     <= '0;
        end else if (bus.i_game_start) begin
            r_state         <= PLAYING;
            r_display_score <= bus.i_score;
            r_display_blank <= 1'b0;
            r_new_record    <= 1'b0;
            r_tick_cnt      <= '0;
            r_phase_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_display_score <= r_high_score;
                end
                PLAYING: begin
                    r_display_score <= bus.i_score;
                    if (bus.i_game_over) begin
                        r_final_score <= bus.i_score;
                        r_state       <= CHECK;
                    end
                end
                CHECK: begin
                    r_display_score <= r_final_score;
                    r_display_blank <= 1'b0;
                    r_tick_cnt      <= '0;
                    r_phase_cnt     <= '0;
                    // Packed BCD orders the same way as plain binary, so an unsigned compare suffices.
                    if (r_final_score > r_high_score) begin
                        r_high_score <= r_final_score;
                        r_new_record <= 1'b1;
                        r_state      <= CELEB;
                    end else begin
                        r_state <= HOLD;
                    end
                end
                CELEB: begin
                    r_display_score <= r_high_score;
                    if (bus.i_game_tick) begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_state         <= HOLD;
                            r_display_blank <= 1'b0;
                            r_tick_cnt      <= '0;
                            r_phase_cnt     <= '0;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                            if (r_phase_cnt == PHASE_LAST) begin
                                r_phase_cnt     <= '0;
                                r_display_blank <= ~r_display_blank;
                            end else begin
                                r_phase_cnt <= r_phase_cnt + 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    r_display_score <= r_final_score;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_display_score = r_display_score;
    assign bus.o_display_blank = r_display_blank;
    assign bus.o_high_score    = r_high_score;
    assign bus.o_new_record    = r_new_record;

endmodule

// File: tb/tb_high_score_tracker.sv
// Self-checking bench for high_score_tracker: an event-level model of the game session
// is compared against the DUT every cycle, plus hand-computed checkpoints.
module tb_high_score_tracker;

    localparam int BLINK_TICKS = 40;
    localparam int BLINK_HALF  = 5;

    localparam logic [2:0] M_IDLE  = 3'd0;
    localparam logic [2:0] M_PLAY  = 3'd1;
    localparam logic [2:0] M_CHECK = 3'd2;
    localparam logic [2:0] M_CELEB = 3'd3;
    localparam logic [2:0] M_HOLD  = 3'd4;

    typedef struct packed {
        logic [2:0]  mode;
        logic [15:0] high;
        logic [15:0] finalScore;
        logic [15:0] disp;
        logic        blank;
        logic        rec;
        logic [7:0]  ticks;
    } model_t;

    logic   clk;
    logic   rst_n;
    int     checks;
    int     errors;
    model_t model;

    high_score_tracker_if bus ();

    high_score_tracker #(
        .BLINK_TICKS (BLINK_TICKS),
        .BLINK_HALF  (BLINK_HALF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next session state from the game rules; blank is derived from the number of ticks celebrated.
    function automatic model_t stepModel(model_t m, logic st, logic ov, logic tk, logic [15:0] sc);
        model_t n;
        n = m;
        if (st) begin
            n.mode  = M_PLAY;
            n.rec   = 1'b0;
            n.ticks = '0;
            n.blank = 1'b0;
            n.disp  = sc;
        end else begin
            case (m.mode)
                M_IDLE: n.disp = m.high;
                M_PLAY: begin
                    n.disp = sc;
                    if (ov) begin
                        n.finalScore = sc;
                        n.mode       = M_CHECK;
                    end
                end
                M_CHECK: begin
                    n.disp  = m.finalScore;
                    n.blank = 1'b0;
                    n.ticks = '0;
                    if (m.finalScore > m.high) begin
                        n.high = m.finalScore;
                        n.rec  = 1'b1;
                        n.mode = M_CELEB;
                    end else begin
                        n.mode = M_HOLD;
                    end
                end
                M_CELEB: begin
                    n.disp = m.high;
                    if (tk) n.ticks = m.ticks + 8'd1;
                    if (int'(n.ticks) == BLINK_TICKS) begin
                        n.mode  = M_HOLD;
                        n.blank = 1'b0;
                    end else begin
                        n.blank = ((int'(n.ticks) / BLINK_HALF) % 2) == 1;
                    end
                end
                default: n.disp = m.finalScore;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model <= '0;
        end else begin
            model <= stepModel(model, bus.i_game_start, bus.i_game_over, bus.i_game_tick, bus.i_score);
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Continuous comparison against the model on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("model_display", bus.o_display_score, model.disp);
            checkOutput("model_blank", {15'd0, bus.o_display_blank}, {15'd0, model.blank});
            checkOutput("model_high", bus.o_high_score, model.high);
            checkOutput("model_record", {15'd0, bus.o_new_record}, {15'd0, model.rec});
        end
    end

    // Drives one cycle of inputs starting at a falling edge; pulses drop at the next falling edge.
    task automatic applyStimulus(input logic st, input logic ov, input logic tk, input logic [15:0] sc);
        bus.i_game_start = st;
        bus.i_game_over  = ov;
        bus.i_game_tick  = tk;
        bus.i_score      = sc;
        @(negedge clk);
        bus.i_game_start = 1'b0;
        bus.i_game_over  = 1'b0;
        bus.i_game_tick  = 1'b0;
    endtask

    task automatic playGame(input logic [15:0] sc);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, sc);
        applyStimulus(1'b0, 1'b1, 1'b0, sc);
        applyStimulus(1'b0, 1'b0, 1'b0, sc);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.i_game_start = 1'b0;
        bus.i_game_over  = 1'b0;
        bus.i_game_tick  = 1'b0;
        bus.i_score      = 16'h0000;
        repeat (3) @(negedge clk);
        checkOutput("reset_display", bus.o_display_score, 16'h0000);
        checkOutput("reset_high", bus.o_high_score, 16'h0000);
        checkOutput("reset_flags", {14'd0, bus.o_display_blank, bus.o_new_record}, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0042);
        checkOutput("idle_over_ignored", bus.o_high_score, 16'h0000);

        // First record: 0x0123
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0123);
        checkOutput("playing_display", bus.o_display_score, 16'h0123);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0123);
        checkOutput("check_no_record_yet", {15'd0, bus.o_new_record}, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0123);
        checkOutput("record_high", bus.o_high_score, 16'h0123);
        checkOutput("record_flag", {15'd0, bus.o_new_record}, 16'h0001);

        // Celebration: ticks separated by idle cycles
        for (int k = 1; k <= BLINK_TICKS; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 16'h0123);
            if (k == 4) checkOutput("blank_after_4", {15'd0, bus.o_display_blank}, 16'h0000);
            if (k == 5) checkOutput("blank_after_5", {15'd0, bus.o_display_blank}, 16'h0001);
            if (k == 10) checkOutput("blank_after_10", {15'd0, bus.o_display_blank}, 16'h0000);
            if (k == 39) checkOutput("blank_after_39", {15'd0, bus.o_display_blank}, 16'h0001);
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0123);
        end
        checkOutput("hold_blank", {15'd0, bus.o_display_blank}, 16'h0000);
        checkOutput("hold_display", bus.o_display_score, 16'h0123);
        checkOutput("hold_record_kept", {15'd0, bus.o_new_record}, 16'h0001);

        // Tie, then lower score
        playGame(16'h0123);
        checkOutput("tie_no_record", {15'd0, bus.o_new_record}, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0123);
        playGame(16'h0099);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0099);
        checkOutput("lower_display", bus.o_display_score, 16'h0099);
        checkOutput("lower_high", bus.o_high_score, 16'h0123);

        // Start and over together while playing
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0050);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0500);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0500);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0500);
        checkOutput("start_over_playing", bus.o_display_score, 16'h0500);
        checkOutput("start_over_high", bus.o_high_score, 16'h0123);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0050);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0050);

        // Start during celebration at tick 7
        playGame(16'h0200);
        repeat (7) applyStimulus(1'b0, 1'b0, 1'b1, 16'h0200);
        checkOutput("celeb_tick7_blank", {15'd0, bus.o_display_blank}, 16'h0001);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0007);
        checkOutput("abort_blank", {15'd0, bus.o_display_blank}, 16'h0000);
        checkOutput("abort_record", {15'd0, bus.o_new_record}, 16'h0000);
        checkOutput("abort_high", bus.o_high_score, 16'h0200);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0007);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0007);

        // BCD carry records, then asynchronous reset mid-celebration
        playGame(16'h0999);
        checkOutput("bcd_0999", bus.o_high_score, 16'h0999);
        playGame(16'h1000);
        checkOutput("bcd_1000", bus.o_high_score, 16'h1000);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b1, 16'h1000);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_display", bus.o_display_score, 16'h0000);
        checkOutput("async_high", bus.o_high_score, 16'h0000);
        checkOutput("async_flags", {14'd0, bus.o_display_blank, bus.o_new_record}, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
